// File: rtl/vernam_pkg.sv
// Shared constants and the Galois LFSR step for the vernam_stream keystream cipher.
package vernam_pkg;

    localparam int unsigned WORD_CNT_W   = 16;
    localparam int unsigned MAX_LFSR_W   = 64;
    localparam logic [15:0] TAPS_DEFAULT = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // One Galois step on a zero-extended state; callers truncate to their LFSR width.
    function automatic logic [MAX_LFSR_W-1:0] galois_step(
        input logic [MAX_LFSR_W-1:0] state,
        input logic [MAX_LFSR_W-1:0] taps
    );
        return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/vernam_stream_if.sv
// Valid/ready stream bundle for vernam_stream: plaintext in, ciphertext and key word out.
interface vernam_stream_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] key_out;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, key_out
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, key_out
    );
endinterface

// File: rtl/vernam_keygen.sv
// Keystream generator: Galois LFSR with run-time reseed and all-zero seed substitution.
module vernam_keygen
    import vernam_pkg::*;
#(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEFAULT),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [DATA_W-1:0] key
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // A zero seed would lock the LFSR, so it is replaced by SEED.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
        end else if (step) begin
            lfsr_d = LFSR_W'(galois_step(MAX_LFSR_W'(lfsr_q), MAX_LFSR_W'(TAPS)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign key = lfsr_q[DATA_W-1:0];

endmodule

// File: rtl/vernam_stream.sv
// Vernam stream cipher: XORs words with an LFSR keystream behind a single registered output stage.
// Optional VERNAM_BYPASS_EN adds a bypass input that passes words through unkeyed.
module vernam_stream
    import vernam_pkg::*;
#(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_DEFAULT),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_ld,
    input  logic [LFSR_W-1:0]     seed_in,
`ifdef VERNAM_BYPASS_EN
    input  logic                  bypass,
`endif
    vernam_stream_if.slave        bus,
    output logic [WORD_CNT_W-1:0] word_cnt
);

    logic                  bypass_c;
    logic                  in_ready_c;
    logic                  accept_c;
    logic                  step_c;
    logic [DATA_W-1:0]     key_c;
    logic [DATA_W-1:0]     key_sel_c;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q,  out_data_d;
    logic [DATA_W-1:0]     key_out_q,   key_out_d;
    logic [WORD_CNT_W-1:0] word_cnt_q,  word_cnt_d;

`ifdef VERNAM_BYPASS_EN
    assign bypass_c = bypass;
`else
    assign bypass_c = 1'b0;
`endif

    // Single output register: a new word may enter whenever the current one leaves this cycle.
    assign in_ready_c = !seed_ld && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign step_c     = accept_c && !bypass_c;
    assign key_sel_c  = bypass_c ? '0 : key_c;

    vernam_keygen #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_keygen (
        .clk     (clk),
        .rst     (rst),
        .step    (step_c),
        .load    (seed_ld),
        .seed_in (seed_in),
        .key     (key_c)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        key_out_d   = key_out_q;
        word_cnt_d  = word_cnt_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data ^ key_sel_c;
            key_out_d   = key_sel_c;
            word_cnt_d  = word_cnt_q + WORD_CNT_W'(1);
        end
        if (seed_ld) begin
            word_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            key_out_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            key_out_q   <= key_out_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.key_out   = key_out_q;
    assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_vernam_stream.sv
// Directed and randomized checks of vernam_stream against a keystream reference model.
module tb_vernam_stream;
    import vernam_pkg::*;

    localparam int unsigned DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_ld;
    logic [15:0] seed_in;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        chain;
    logic        bp;
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    vernam_stream_if #(.DATA_W(DW)) a_if ();
    vernam_stream_if #(.DATA_W(DW)) b_if ();

    assign a_if.in_valid  = in_valid;
    assign a_if.in_data   = in_data;
    assign a_if.out_ready = chain ? b_if.in_ready : out_ready;
    assign b_if.in_valid  = chain & a_if.out_valid;
    assign b_if.in_data   = a_if.out_data;
    assign b_if.out_ready = 1'b1;

    vernam_stream #(.DATA_W(DW), .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .seed_ld  (seed_ld),
        .seed_in  (seed_in),
`ifdef VERNAM_BYPASS_EN
        .bypass   (bp),
`endif
        .bus      (a_if),
        .word_cnt (a_cnt)
    );

    vernam_stream #(.DATA_W(DW), .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .seed_ld  (1'b0),
        .seed_in  (16'h0000),
`ifdef VERNAM_BYPASS_EN
        .bypass   (1'b0),
`endif
        .bus      (b_if),
        .word_cnt (b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keystream rule: key is the low byte before the step; right shift, XOR taps when the lsb was 1.
    task automatic model_step(output logic [7:0] key);
        key = bp ? 8'h00 : m_lfsr[7:0];
        if (!bp) begin
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
        end
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic model_reset(input logic [15:0] s);
        m_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
        m_cnt  = 16'h0000;
    endtask

    // Called just after a rising edge; offers one word, checks the registered result, returns what was seen.
    task automatic send(input logic [7:0] d, output logic [7:0] key,
                        output logic [7:0] od, output logic [7:0] ok);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!a_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(a_if.in_ready), 32'd1);
        model_step(key);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        od = a_if.out_data;
        ok = a_if.key_out;
        chk("send_valid", 32'(a_if.out_valid), 32'd1);
        chk("send_data", 32'(od), 32'(d ^ key));
        chk("send_key", 32'(ok), 32'(key));
        chk("send_cnt", 32'(a_cnt), 32'(m_cnt));
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset(16'h0000);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  k, k2, od, ok;
        logic [15:0] expq[$];
        logic [15:0] s;
        string       msg;
        int          idx, got;

        rst = 1'b0; seed_ld = 1'b0; seed_in = 16'h0; in_valid = 1'b0; in_data = 8'h0;
        out_ready = 1'b1; chain = 1'b0; bp = 1'b0;
        model_reset(16'h0000);
        #12;
        chk("rst_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_data", 32'(a_if.out_data), 32'd0);
        chk("rst_key", 32'(a_if.key_out), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk("rst_ready", 32'(a_if.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Plain stream "h","e"
        send(8'h68, k, od, ok);
        chk("t1_data0", 32'(od), 32'h89);
        chk("t1_key0", 32'(ok), 32'hE1);
        send(8'h65, k, od, ok);
        chk("t1_data1", 32'(od), 32'h15);
        chk("t1_key1", 32'(ok), 32'h70);
        chk("t1_cnt", 32'(a_cnt), 32'd2);

        // Backpressure: held output, in_ready low, no skipped key
        out_ready = 1'b0;
        send(8'h6C, k, od, ok);
        in_valid = 1'b1;
        in_data  = 8'h6F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_ready_lo", 32'(a_if.in_ready), 32'd0);
            chk("t2_hold_data", 32'(a_if.out_data), 32'(8'h6C ^ k));
            chk("t2_hold_key", 32'(a_if.key_out), 32'(k));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_ready_hi", 32'(a_if.in_ready), 32'd1);
        model_step(k2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_valid", 32'(a_if.out_valid), 32'd1);
        chk("t2_data", 32'(a_if.out_data), 32'(8'h6F ^ k2));
        chk("t2_key", 32'(a_if.key_out), 32'h9C);
        @(posedge clk); #1;

        // Zero-seed load with a pending output
        out_ready = 1'b0;
        send(8'h78, k, od, ok);
        seed_ld  = 1'b1;
        seed_in  = 16'h0000;
        in_valid = 1'b1;
        in_data  = 8'h79;
        @(negedge clk);
        chk("t3_ready_ld", 32'(a_if.in_ready), 32'd0);
        @(posedge clk); #1;
        seed_ld = 1'b0;
        model_reset(16'h0000);
        @(negedge clk);
        chk("t3_cnt0", 32'(a_cnt), 32'd0);
        chk("t3_pend_valid", 32'(a_if.out_valid), 32'd1);
        chk("t3_pend_data", 32'(a_if.out_data), 32'(8'h78 ^ k));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain_valid", 32'(a_if.out_valid), 32'd1);
        chk("t3_drain_data", 32'(a_if.out_data), 32'(8'h78 ^ k));
        chk("t3_ready", 32'(a_if.in_ready), 32'd1);
        model_step(k2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_data", 32'(a_if.out_data), 32'(8'h79 ^ 8'hE1));
        chk("t3_key", 32'(a_if.key_out), 32'hE1);
        chk("t3_cnt1", 32'(a_cnt), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(8'h7A, k, od, ok);
        rst = 1'b0;
        #1;
        chk("t5_valid", 32'(a_if.out_valid), 32'd0);
        chk("t5_cnt", 32'(a_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset(16'h0000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h68, k, od, ok);
        chk("t5_key", 32'(ok), 32'hE1);

        // Encrypt then decrypt through a second instance
        pulse_reset();
        chain = 1'b1;
        msg = "helloworld2";
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < msg.len(); cyc++) begin
            in_valid = (idx < msg.len());
            in_data  = (idx < msg.len()) ? msg[idx] : 8'h00;
            @(negedge clk);
            if (a_if.out_valid && b_if.in_ready) begin
                chk("t4_cipher", 32'(a_if.out_data), 32'(expq[0][15:8]));
                expq.pop_front();
            end
            if (b_if.out_valid) begin
                chk("t4_plain", 32'(b_if.out_data), 32'(msg[got]));
                got++;
            end
            if (in_valid && a_if.in_ready) begin
                model_step(k);
                expq.push_back({msg[idx] ^ k, k});
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chain = 1'b0;
        chk("t4_got", 32'(got), 32'(msg.len()));
        chk("t4_cnt_a", 32'(a_cnt), 32'd11);
        chk("t4_cnt_b", 32'(b_cnt), 32'd11);
        expq.delete();

`ifdef VERNAM_BYPASS_EN
        // Bypass word does not consume a key
        pulse_reset();
        out_ready = 1'b1;
        send(8'h68, k, od, ok);
        chk("t6_key0", 32'(ok), 32'hE1);
        bp = 1'b1;
        send(8'h41, k, od, ok);
        chk("t6_bp_data", 32'(od), 32'h41);
        chk("t6_bp_key", 32'(ok), 32'h00);
        bp = 1'b0;
        send(8'h42, k, od, ok);
        chk("t6_key2", 32'(ok), 32'h70);
        chk("t6_cnt", 32'(a_cnt), 32'd3);
`endif

        // Randomized traffic after a random nonzero reseed
        s = 16'($urandom_range(1, 65535));
        seed_ld = 1'b1;
        seed_in = s;
        @(posedge clk); #1;
        seed_ld = 1'b0;
        model_reset(s);
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef VERNAM_BYPASS_EN
            bp = ($urandom_range(0, 7) == 0);
`endif
            @(negedge clk);
            chk("rnd_ready", 32'(a_if.in_ready), 32'(!a_if.out_valid || out_ready));
            chk("rnd_valid", 32'(a_if.out_valid), 32'(expq.size() != 0));
            if (a_if.out_valid && expq.size() != 0) begin
                chk("rnd_data", 32'({a_if.out_data, a_if.key_out}), 32'(expq[0]));
                if (out_ready) expq.pop_front();
            end
            if (in_valid && a_if.in_ready) begin
                model_step(k);
                expq.push_back({in_data ^ k, k});
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bp        = 1'b0;
        @(negedge clk);
        if (a_if.out_valid && expq.size() != 0) begin
            chk("rnd_last", 32'({a_if.out_data, a_if.key_out}), 32'(expq[0]));
            expq.pop_front();
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("rnd_drained", 32'(a_if.out_valid), 32'd0);
        chk("rnd_cnt", 32'(a_cnt), 32'(m_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
